// File: rtl/alu_multicycle_if.sv
// Start/ready handshake and operand/result bus between the core and alu_multicycle.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               ctrl_start;
  logic [4:0]         ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic               ctrl_ready;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;
  logic               data_exception;

  modport master (
    output ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    input  ctrl_ready, data_result, data_resultRDY, isNotEqual, isLessThan, overflow, data_exception
  );

  modport slave (
    input  ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    output ctrl_ready, data_result, data_resultRDY, isNotEqual, isLessThan, overflow, data_exception
  );
endinterface

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle ADD/SUB/AND/OR/SLL/SRA, iterative signed MUL/DIV behind start/ready.
// Define ALU_DIV_EN to build the restoring divider; without it DIV reports an unsupported opcode.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_multicycle_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OP_DIV = 5'b00111;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mag_q, mag_d;   // |A| for MUL, divisor |B| for DIV
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier+product low half / dividend+quotient
`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
`endif
  logic             ready_q, ready_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;

  // Single-cycle datapath on the live bus, valid at the accept edge
  logic [WIDTH-1:0]        in_a, in_b, abs_a, abs_b;
  logic [WIDTH-1:0]        add_res, sub_res, sll_res, sra_res;
  logic signed [WIDTH-1:0] sra_raw;
  logic                    add_ovf, sub_ovf, shift_full, long_op;

  assign in_a       = bus.data_operandA;
  assign in_b       = bus.data_operandB;
  assign abs_a      = in_a[WIDTH-1] ? -in_a : in_a;
  assign abs_b      = in_b[WIDTH-1] ? -in_b : in_b;
  assign add_res    = in_a + in_b;
  assign sub_res    = in_a - in_b;
  assign add_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_res[WIDTH-1] != in_a[WIDTH-1]);
  assign sub_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_res[WIDTH-1] != in_a[WIDTH-1]);
  assign shift_full = 32'(bus.ctrl_shiftamt) >= WIDTH;
  assign sll_res    = shift_full ? '0 : (in_a << bus.ctrl_shiftamt);
  assign sra_raw    = $signed(in_a) >>> bus.ctrl_shiftamt;
  assign sra_res    = shift_full ? {WIDTH{in_a[WIDTH-1]}} : sra_raw;
`ifdef ALU_DIV_EN
  assign long_op    = (bus.ctrl_ALUopcode == OP_MUL) || (bus.ctrl_ALUopcode == OP_DIV);
`else
  assign long_op    = (bus.ctrl_ALUopcode == OP_MUL);
`endif

  // Shift-add multiply step; final sign applied to the full double-width product
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nxt, mul_lo_nxt;
  logic [PW-1:0]    mul_prod, mul_signed;
  logic             mul_ovf;

  assign mul_sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
  assign mul_acc_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign mul_prod    = {mul_acc_nxt, mul_lo_nxt};
  assign mul_signed  = neg_q ? -mul_prod : mul_prod;
  assign mul_ovf     = (mul_signed[PW-1:WIDTH-1] != '0) && (mul_signed[PW-1:WIDTH-1] != '1);

`ifdef ALU_DIV_EN
  // Restoring divide step on magnitudes; quotient bits shift into lo
  logic [WIDTH:0]   div_shift, div_rem;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok, div_zero, div_min_neg1;
  logic [WIDTH-1:0] div_acc_nxt, div_lo_nxt, div_quo;

  assign div_shift    = {acc_q, lo_q[WIDTH-1]};
  assign div_trial    = {1'b0, div_shift} - {2'b00, mag_q};
  assign div_ok       = ~div_trial[WIDTH+1];
  assign div_rem      = div_ok ? div_trial[WIDTH:0] : div_shift;
  assign div_acc_nxt  = WIDTH'(div_rem);
  assign div_lo_nxt   = {lo_q[WIDTH-2:0], div_ok};
  assign div_quo      = neg_q ? -div_lo_nxt : div_lo_nxt;
  assign div_zero     = (b_q == '0);
  assign div_min_neg1 = (a_q == MIN_VAL) && (b_q == '1);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
`endif
    ready_d  = ready_q;
    rdy_d    = 1'b0;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_start) begin
          a_d     = in_a;
          b_d     = in_b;
          neg_d   = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          cnt_d   = '0;
          ready_d = 1'b0;
          if (long_op) begin
            state_d = S_BUSY;
            acc_d   = '0;
            mag_d   = abs_a;
            lo_d    = abs_b;
`ifdef ALU_DIV_EN
            is_div_d = (bus.ctrl_ALUopcode == OP_DIV);
            if (is_div_d) begin
              mag_d = abs_b;
              lo_d  = abs_a;
            end
`endif
          end else begin
            state_d  = S_DONE;
            rdy_d    = 1'b1;
            ne_d     = (in_a != in_b);
            lt_d     = $signed(in_a) < $signed(in_b);
            ovf_d    = 1'b0;
            exc_d    = 1'b0;
            result_d = '0;
            case (bus.ctrl_ALUopcode)
              OP_ADD: begin result_d = add_res; ovf_d = add_ovf; end
              OP_SUB: begin result_d = sub_res; ovf_d = sub_ovf; end
              OP_AND: result_d = in_a & in_b;
              OP_OR:  result_d = in_a | in_b;
              OP_SLL: result_d = sll_res;
              OP_SRA: result_d = sra_res;
              default: exc_d = 1'b1;
            endcase
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = mul_acc_nxt;
        lo_d  = mul_lo_nxt;
`ifdef ALU_DIV_EN
        if (is_div_q) begin
          acc_d = div_acc_nxt;
          lo_d  = div_lo_nxt;
        end
`endif
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          rdy_d    = 1'b1;
          cnt_d    = '0;
          ne_d     = (a_q != b_q);
          lt_d     = $signed(a_q) < $signed(b_q);
          result_d = mul_signed[WIDTH-1:0];
          ovf_d    = mul_ovf;
          exc_d    = 1'b0;
`ifdef ALU_DIV_EN
          if (is_div_q) begin
            result_d = div_zero ? '0 : div_quo;
            ovf_d    = div_min_neg1;
            exc_d    = div_zero;
          end
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
      ready_q  <= 1'b1;
      rdy_q    <= 1'b0;
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
`ifdef ALU_DIV_EN
      is_div_q <= is_div_d;
`endif
      ready_q  <= ready_d;
      rdy_q    <= rdy_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.ctrl_ready     = ready_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_result    = result_q;
  assign bus.isNotEqual     = ne_q;
  assign bus.isLessThan     = lt_q;
  assign bus.overflow       = ovf_q;
  assign bus.data_exception = exc_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: arithmetic reference model plus per-cycle output compare.
module tb_alu_multicycle;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;
  localparam logic [4:0] OP_BAD = 5'd8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    logic [31:0] res;
    logic        ne, lt, ovf, exc;
    int          due;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_multicycle_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
  alu_multicycle #(.WIDTH(W), .SHAMT_W(SW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  int busy_until = 0;
  exp_t expq[$];
  exp_t mdl_e;
  logic [31:0] cur_res = '0;
  logic cur_ne = 1'b0, cur_lt = 1'b0, cur_ovf = 1'b0, cur_exc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, edge_n + 1);
    end
  endtask

  function automatic int lat(input logic [4:0] op);
    if (op == OP_MUL) return W + 1;
`ifdef ALU_DIV_EN
    if (op == OP_DIV) return W + 1;
`endif
    return 1;
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t e;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = 0;
    e.res = '0; e.ne = (a != b); e.lt = (sa < sb); e.ovf = 1'b0; e.exc = 1'b0; e.due = 0;
    case (op)
      OP_ADD: begin t = sa + sb; e.res = t[31:0]; e.ovf = (t > MAXV) || (t < MINV); end
      OP_SUB: begin t = sa - sb; e.res = t[31:0]; e.ovf = (t > MAXV) || (t < MINV); end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_SLL: begin t = longint'(a) << sh; e.res = t[31:0]; end
      OP_SRA: begin t = sa >>> sh; e.res = t[31:0]; end
      OP_MUL: begin t = sa * sb; e.res = t[31:0]; e.ovf = (t > MAXV) || (t < MINV); end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (sb == 0) e.exc = 1'b1;
        else begin t = sa / sb; e.res = t[31:0]; e.ovf = (t > MAXV) || (t < MINV); end
      end
`endif
      default: e.exc = 1'b1;
    endcase
    return e;
  endfunction

  // Model: decides acceptance from its own busy window and schedules the completion cycle
  always @(posedge clock) begin
    edge_n++;
    if (!reset_n) begin
      expq.delete();
      busy_until = edge_n;
      cur_res = '0; cur_ne = 1'b0; cur_lt = 1'b0; cur_ovf = 1'b0; cur_exc = 1'b0;
    end else if (bus.ctrl_start && edge_n > busy_until) begin
      mdl_e = model(bus.ctrl_ALUopcode, bus.data_operandA, bus.data_operandB, bus.ctrl_shiftamt);
      mdl_e.due = edge_n + lat(bus.ctrl_ALUopcode);
      busy_until = mdl_e.due;
      expq.push_back(mdl_e);
    end
  end

  // Compare every cycle, just after the edge
  always @(posedge clock) begin
    logic exp_rdy;
    #1;
    exp_rdy = (expq.size() > 0) && (expq[0].due == edge_n + 1);
    if (exp_rdy) begin
      cur_res = expq[0].res; cur_ne = expq[0].ne; cur_lt = expq[0].lt;
      cur_ovf = expq[0].ovf; cur_exc = expq[0].exc;
      void'(expq.pop_front());
    end
    chk("ready",     32'(bus.ctrl_ready),     32'(edge_n + 1 > busy_until));
    chk("resultRDY", 32'(bus.data_resultRDY), 32'(exp_rdy));
    chk("result",    bus.data_result,         cur_res);
    chk("isNotEqual", 32'(bus.isNotEqual),    32'(cur_ne));
    chk("isLessThan", 32'(bus.isLessThan),    32'(cur_lt));
    chk("overflow",   32'(bus.overflow),      32'(cur_ovf));
    chk("exception",  32'(bus.data_exception), 32'(cur_exc));
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    while (edge_n + 1 <= busy_until) @(negedge clock);
    bus.ctrl_ALUopcode = op; bus.data_operandA = a; bus.data_operandB = b;
    bus.ctrl_shiftamt = sh; bus.ctrl_start = 1'b1;
    @(negedge clock);
    bus.ctrl_start = 1'b0;
    bus.ctrl_ALUopcode = 5'($urandom); bus.data_operandA = $urandom; bus.data_operandB = $urandom;
    bus.ctrl_shiftamt = 5'($urandom);
  endtask

  // Hand-computed expectations pin the model, then the vector runs on the DUT
  task automatic vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] res,
                     input logic ne, input logic lt, input logic ovf, input logic exc);
    exp_t m;
    m = model(op, a, b, sh);
    chk("pin_result", m.res, res);
    chk("pin_flags", 32'({m.ne, m.lt, m.ovf, m.exc}), 32'({ne, lt, ovf, exc}));
    issue(op, a, b, sh);
  endtask

  initial begin
    logic [4:0] rop;
    bus.ctrl_start = 1'b0; bus.ctrl_ALUopcode = '0; bus.ctrl_shiftamt = '0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    chk("pin_lat_add", 32'(lat(OP_ADD)), 32'd1);
    chk("pin_lat_mul", 32'(lat(OP_MUL)), 32'd33);

    vec(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1, 0, 1, 0);
    vec(OP_SUB, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 0, 0, 0, 0);
    vec(OP_SRA, 32'h80000000, 32'h00000000, 5'd4, 32'hF8000000, 1, 1, 0, 0);
    vec(OP_MUL, 32'hFFFFFFF9, 32'h00000006, 5'd0, 32'hFFFFFFD6, 1, 1, 0, 0);
    vec(OP_MUL, 32'h00010000, 32'h00010000, 5'd0, 32'h00000000, 0, 0, 1, 0);
    vec(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1, 1, 0, 0);
    vec(OP_OR,  32'h12340000, 32'h00005678, 5'd0, 32'h12345678, 1, 0, 0, 0);
    vec(OP_SLL, 32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 1, 0, 0, 0);
    vec(OP_SUB, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1, 1, 1, 0);
    vec(OP_BAD, 32'h00000003, 32'h00000003, 5'd0, 32'h00000000, 0, 0, 0, 1);
    vec(OP_ADD, 32'h00000001, 32'h00000002, 5'd0, 32'h00000003, 1, 1, 0, 0);
    vec(OP_MUL, 32'h7FFFFFFF, 32'h00000002, 5'd0, 32'hFFFFFFFE, 1, 0, 1, 0);
    vec(OP_MUL, 32'h80000000, 32'h00000001, 5'd0, 32'h80000000, 1, 1, 0, 0);
`ifdef ALU_DIV_EN
    vec(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 5'd0, 32'hFFFFFFFD, 1, 1, 0, 0);
    vec(OP_DIV, 32'h00000005, 32'h00000000, 5'd0, 32'h00000000, 1, 0, 0, 1);
    vec(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1, 1, 1, 0);
    vec(OP_ADD, 32'h00000004, 32'h00000004, 5'd0, 32'h00000008, 0, 0, 0, 0);
`else
    vec(OP_DIV, 32'h00000008, 32'h00000002, 5'd0, 32'h00000000, 1, 0, 0, 1);
`endif

    // Start pulse while BUSY must be dropped, not queued
    issue(OP_MUL, 32'h00000003, 32'h00000005, 5'd0);
    repeat (3) @(negedge clock);
    bus.ctrl_ALUopcode = OP_ADD; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    bus.ctrl_start = 1'b1;
    @(negedge clock);
    bus.ctrl_start = 1'b0;

    // Reset in the middle of a multiply aborts it silently
    issue(OP_MUL, 32'hFFFFFFF9, 32'h00000006, 5'd0);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue(OP_SUB, 32'h00000002, 32'h00000007, 5'd0);

    for (int i = 0; i < 24; i++) begin
      rop = 5'($urandom_range(0, 8));
      issue(rop, $urandom, (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom, 5'($urandom));
    end

    repeat (40) @(negedge clock);
    chk("drain", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
